// File: rtl/gmii_rx_frame_arbiter.sv
// ============================================================================
// Module   : gmii_rx_frame_arbiter
// Brief    : Frame-granular round-robin drain of per-port GMII rx FIFOs into
//            one shared 9-bit write port; drops orphans, truncates runaways.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gmii_rx_frame_arbiter #(
    parameter int PORT_NUM  = 4,
    parameter int MAX_WORDS = 1536,
    parameter int CNT_W     = 11
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [PORT_NUM*9-1:0] iv_fifo_rdata,
    input  logic [PORT_NUM-1:0]   iv_fifo_empty,
    output logic [PORT_NUM-1:0]   ov_fifo_rd,
    output logic [8:0]            ov_data,
    output logic                  o_data_wr,
    input  logic                  i_data_full,
    output logic [2:0]            ov_port_id,
    output logic                  o_frame_trunc_pulse,
    output logic                  o_orphan_pulse
);

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        HEAD_S  = 2'd1,
        TRANS_S = 2'd2,
        DISC_S  = 2'd3
    } state_t;

    localparam logic [2:0]       c_last_port = 3'(PORT_NUM - 1);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(MAX_WORDS - 1);

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [8:0]       data_q, data_d;
    logic             data_wr_q, data_wr_d;
    logic [2:0]       port_id_q, port_id_d;
    logic             trunc_q, trunc_d;
    logic             orphan_q, orphan_d;

    // Pad to 8 slots so a 3-bit grant indexes without range issues; unused
    // slots look permanently empty and are never selected.
    logic [8:0] port_word [8];
    logic [7:0] port_empty;

    for (genvar p = 0; p < 8; p++) begin : g_port
        if (p < PORT_NUM) begin : g_used
            assign port_word[p]  = iv_fifo_rdata[p*9 +: 9];
            assign port_empty[p] = iv_fifo_empty[p];
        end else begin : g_unused
            assign port_word[p]  = 9'd0;
            assign port_empty[p] = 1'b1;
        end
    end

    logic [8:0] cur_word;
    logic       cur_empty;
    assign cur_word  = port_word[grant_q];
    assign cur_empty = port_empty[grant_q];

    logic       scan_hit;
    logic [2:0] scan_port;
    logic [3:0] scan_idx;

    always_comb begin
        scan_hit  = 1'b0;
        scan_port = 3'd0;
        scan_idx  = 4'd0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            scan_idx = {1'b0, last_grant_q} + 4'(i);
            if (scan_idx >= 4'(PORT_NUM)) begin
                scan_idx = scan_idx - 4'(PORT_NUM);
            end
            if (!scan_hit && !port_empty[scan_idx[2:0]]) begin
                scan_hit  = 1'b1;
                scan_port = scan_idx[2:0];
            end
        end
    end

    logic       rd_en;
    logic [7:0] rd_vec;

    always_comb begin
        rd_en  = 1'b0;
        rd_vec = 8'd0;
        case (state_q)
            HEAD_S, TRANS_S: rd_en = !cur_empty && !i_data_full;
            DISC_S:          rd_en = !cur_empty;
            default:         rd_en = 1'b0;
        endcase
        rd_vec[grant_q] = rd_en;
    end

    assign ov_fifo_rd = rd_vec[PORT_NUM-1:0];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        data_d       = data_q;
        data_wr_d    = 1'b0;
        port_id_d    = port_id_q;
        trunc_d      = 1'b0;
        orphan_d     = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (scan_hit) begin
                    grant_d   = scan_port;
                    port_id_d = scan_port;
                    state_d   = HEAD_S;
                end
            end
            HEAD_S: begin
                if (rd_en) begin
                    if (cur_word[8]) begin
                        data_d     = cur_word;
                        data_wr_d  = 1'b1;
                        word_cnt_d = CNT_W'(1);
                        state_d    = TRANS_S;
                    end else begin
                        orphan_d = 1'b1;
                        state_d  = DISC_S;
                    end
                end
            end
            TRANS_S: begin
                if (rd_en) begin
                    data_d    = cur_word;
                    data_wr_d = 1'b1;
                    if (cur_word[8]) begin
                        last_grant_d = grant_q;
                        word_cnt_d   = '0;
                        state_d      = IDLE_S;
                    end else if (word_cnt_q == c_cnt_last) begin
                        // Close the frame downstream with a forced tail flag.
                        data_d       = {1'b1, cur_word[7:0]};
                        trunc_d      = 1'b1;
                        last_grant_d = grant_q;
                        word_cnt_d   = '0;
                        state_d      = DISC_S;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            DISC_S: begin
                if (rd_en && cur_word[8]) begin
                    last_grant_d = grant_q;
                    word_cnt_d   = '0;
                    state_d      = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE_S;
            grant_q      <= 3'd0;
            last_grant_q <= c_last_port;
            word_cnt_q   <= '0;
            data_q       <= 9'd0;
            data_wr_q    <= 1'b0;
            port_id_q    <= 3'd0;
            trunc_q      <= 1'b0;
            orphan_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
            data_q       <= data_d;
            data_wr_q    <= data_wr_d;
            port_id_q    <= port_id_d;
            trunc_q      <= trunc_d;
            orphan_q     <= orphan_d;
        end
    end

    assign ov_data             = data_q;
    assign o_data_wr           = data_wr_q;
    assign ov_port_id          = port_id_q;
    assign o_frame_trunc_pulse = trunc_q;
    assign o_orphan_pulse      = orphan_q;

endmodule

`default_nettype wire

// File: tb/tb_gmii_rx_frame_arbiter.sv
// ============================================================================
// Module   : tb_gmii_rx_frame_arbiter
// Brief    : Self-checking bench: queue-modelled FIFOs, frame-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gmii_rx_frame_arbiter;

    localparam int PN   = 4;
    localparam int MAXW = 72;   // small enough to truncate, large enough for 64-word frames
    localparam int CW   = 7;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic [PN*9-1:0] iv_fifo_rdata;
    logic [PN-1:0]   iv_fifo_empty;
    logic [PN-1:0]   ov_fifo_rd;
    logic [8:0]      ov_data;
    logic            o_data_wr;
    logic            i_data_full;
    logic [2:0]      ov_port_id;
    logic            o_frame_trunc_pulse;
    logic            o_orphan_pulse;

    gmii_rx_frame_arbiter #(.PORT_NUM(PN), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk_sys             (clk_sys),
        .reset_n             (reset_n),
        .iv_fifo_rdata       (iv_fifo_rdata),
        .iv_fifo_empty       (iv_fifo_empty),
        .ov_fifo_rd          (ov_fifo_rd),
        .ov_data             (ov_data),
        .o_data_wr           (o_data_wr),
        .i_data_full         (i_data_full),
        .ov_port_id          (ov_port_id),
        .o_frame_trunc_pulse (o_frame_trunc_pulse),
        .o_orphan_pulse      (o_orphan_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        int port;   int len;      int orphan;
        int port_b; int len_b;
        int full_at; int full_len;
        int gap_at;  int gap_len;
        int exp_wr;  int exp_trunc; int exp_orphan;
    } vec_t;

    logic [8:0] fifo_q [PN][$];
    logic [8:0] exp_q  [PN][$];
    int         port_log[$];

    int n_checks = 0, n_fail = 0;
    int wr_total, trunc_seen, orphan_seen, exp_trunc, exp_orphan;
    int rd_total [PN];
    int gap_left [PN];
    int full_left = 0;
    int trig_full_at = -1, trig_full_len = 0;
    int trig_gap_port = 0, trig_gap_at = -1, trig_gap_len = 0;
    int rand_full_pct = 0, rand_gap_pct = 0;
    bit prev_fwd_ok = 0, prev_wr = 0, prev_trunc = 0, prev_orphan = 0;
    bit in_frame = 0;
    logic [8:0] last_data = 9'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic make_frame(input int len, input int orphan, output logic [8:0] w[$]);
        logic [7:0] b;
        bit         f;
        w.delete();
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(255));
            f = (k == 0 && orphan == 0) || (k == len - 1);
            if (k == 0 && orphan != 0) b = 8'h55;
            w.push_back({f, b});
        end
    endtask

    // Load words into a port FIFO and derive what should come out of it.
    task automatic push_words(input int p, input logic [8:0] w[$]);
        int i, j, n;
        logic [8:0] t;
        n = w.size();
        foreach (w[k]) fifo_q[p].push_back(w[k]);
        i = 0;
        while (i < n) begin
            j = i + 1;
            while (j < n && !w[j][8]) j++;
            if (w[i][8]) begin
                if (j - i + 1 <= MAXW) begin
                    for (int k = i; k <= j; k++) exp_q[p].push_back(w[k]);
                end else begin
                    for (int k = i; k < i + MAXW - 1; k++) exp_q[p].push_back(w[k]);
                    t = w[i + MAXW - 1];
                    exp_q[p].push_back({1'b1, t[7:0]});
                    exp_trunc++;
                end
            end else begin
                exp_orphan++;
            end
            i = j + 1;
        end
    endtask

    function automatic bit drained();
        for (int p = 0; p < PN; p++)
            if (fifo_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_counts();
        wr_total = 0; trunc_seen = 0; orphan_seen = 0;
        exp_trunc = 0; exp_orphan = 0;
        port_log.delete();
        for (int p = 0; p < PN; p++) begin rd_total[p] = 0; gap_left[p] = 0; end
    endtask

    task automatic cycle();
        logic [PN-1:0] rd;
        int            port;
        logic [8:0]    e;
        @(negedge clk_sys);
        if (trig_full_at >= 0 && wr_total >= trig_full_at) begin
            full_left = trig_full_len; trig_full_at = -1;
        end
        if (trig_gap_at >= 0 && rd_total[trig_gap_port] >= trig_gap_at) begin
            gap_left[trig_gap_port] = trig_gap_len; trig_gap_at = -1;
        end
        for (int p = 0; p < PN; p++) begin
            iv_fifo_rdata[p*9 +: 9] = (fifo_q[p].size() > 0) ? fifo_q[p][0] : 9'd0;
            iv_fifo_empty[p] = (fifo_q[p].size() == 0) || (gap_left[p] > 0) ||
                               (rand_gap_pct > 0 && $urandom_range(99) < rand_gap_pct);
            if (gap_left[p] > 0) gap_left[p]--;
        end
        i_data_full = (full_left > 0) || (rand_full_pct > 0 && $urandom_range(99) < rand_full_pct);
        if (full_left > 0) full_left--;
        #1;
        rd = ov_fifo_rd;
        chk("rd_onehot", 64'($countones(rd) > 1), 0);
        chk("rd_when_empty", 64'((rd & iv_fifo_empty) != 0), 0);

        if (o_data_wr) begin
            chk("wr_after_fwd_read", 64'(prev_fwd_ok), 1);
            port = int'(ov_port_id);
            if (port >= PN || exp_q[port % PN].size() == 0) begin
                chk("unexpected_write_port", 64'(port), 64'(PN));
            end else begin
                e = exp_q[port].pop_front();
                chk("data_word", 64'(ov_data), 64'(e));
            end
            if (!in_frame) begin
                chk("frame_gap", 64'(prev_wr), 0);
                chk("head_flag", 64'(ov_data[8]), 1);
                port_log.push_back(port);
                in_frame = 1'b1;
            end else if (ov_data[8]) begin
                in_frame = 1'b0;
            end
            wr_total++;
            last_data = ov_data;
        end else begin
            chk("data_hold", 64'(ov_data), 64'(last_data));
        end
        if (o_frame_trunc_pulse) begin
            trunc_seen++;
            chk("trunc_one_cycle", 64'(prev_trunc), 0);
        end
        if (o_orphan_pulse) begin
            orphan_seen++;
            chk("orphan_one_cycle", 64'(prev_orphan), 0);
        end
        prev_wr     = o_data_wr;
        prev_trunc  = o_frame_trunc_pulse;
        prev_orphan = o_orphan_pulse;

        for (int p = 0; p < PN; p++) begin
            if (rd[p] && fifo_q[p].size() > 0) begin
                void'(fifo_q[p].pop_front());
                rd_total[p]++;
            end
        end
        prev_fwd_ok = (rd != 0) && !i_data_full;
    endtask

    task automatic run_drain(input string name, input int budget);
        int c = 0;
        while (!drained() && c < budget) begin cycle(); c++; end
        chk({name, "_drained"}, 64'(drained()), 1);
        repeat (4) cycle();
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_data"},   64'(ov_data), 0);
        chk({name, "_wr"},     64'(o_data_wr), 0);
        chk({name, "_port"},   64'(ov_port_id), 0);
        chk({name, "_trunc"},  64'(o_frame_trunc_pulse), 0);
        chk({name, "_orphan"}, 64'(o_orphan_pulse), 0);
        chk({name, "_rd"},     64'(ov_fifo_rd), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [8];
        logic [8:0] w[$];
        logic [8:0] tmp[$];
        int         first, frames, c, exp_words;

        vecs[0] = '{1, 10, 0, -1, 0,  4, 5, -1, 0, 10, 0, 0};
        vecs[1] = '{3, 20, 0, -1, 0, -1, 0,  3, 7, 20, 0, 0};
        vecs[2] = '{0, 76, 0,  1, 4, -1, 0, -1, 0, 76, 1, 0};
        vecs[3] = '{2,  4, 1, -1, 0, -1, 0, -1, 0,  0, 0, 1};
        vecs[4] = '{1, 72, 0, -1, 0, -1, 0, -1, 0, 72, 0, 0};
        vecs[5] = '{2, 73, 0, -1, 0, -1, 0, -1, 0, 72, 1, 0};
        vecs[6] = '{3,  2, 0, -1, 0, -1, 0, -1, 0,  2, 0, 0};
        vecs[7] = '{0,  3, 1,  0, 5, -1, 0, -1, 0,  5, 0, 1};

        reset_n       = 1'b0;
        iv_fifo_rdata = '0;
        iv_fifo_empty = '1;
        i_data_full   = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk_sys);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Two ports queued together: port 0 first since last_grant resets to 3.
        clear_counts();
        make_frame(64, 0, w); push_words(0, w);
        make_frame(64, 0, w); push_words(2, w);
        run_drain("two_port", 2000);
        chk("two_port_writes", 64'(wr_total), 128);
        chk("two_port_frames", 64'(port_log.size()), 2);
        if (port_log.size() == 2) begin
            chk("two_port_first", 64'(port_log[0]), 0);
            chk("two_port_second", 64'(port_log[1]), 2);
        end

        for (int v = 0; v < 8; v++) begin
            clear_counts();
            make_frame(vecs[v].len, vecs[v].orphan, w);
            push_words(vecs[v].port, w);
            if (vecs[v].len_b > 0) begin
                make_frame(vecs[v].len_b, 0, w);
                push_words(vecs[v].port_b, w);
            end
            trig_full_at  = vecs[v].full_at;
            trig_full_len = vecs[v].full_len;
            trig_gap_port = vecs[v].port;
            trig_gap_at   = vecs[v].gap_at;
            trig_gap_len  = vecs[v].gap_len;
            run_drain($sformatf("vec%0d", v), 1000);
            chk($sformatf("vec%0d_writes", v), 64'(wr_total), 64'(vecs[v].exp_wr));
            chk($sformatf("vec%0d_trunc", v), 64'(trunc_seen), 64'(vecs[v].exp_trunc));
            chk($sformatf("vec%0d_orphan", v), 64'(orphan_seen), 64'(vecs[v].exp_orphan));
            frames = (vecs[v].orphan == 0 ? 1 : 0) + (vecs[v].len_b > 0 ? 1 : 0);
            chk($sformatf("vec%0d_frames", v), 64'(port_log.size()), 64'(frames));
            first = (vecs[v].orphan != 0) ? vecs[v].port_b : vecs[v].port;
            if (frames > 0 && port_log.size() > 0)
                chk($sformatf("vec%0d_first_port", v), 64'(port_log[0]), 64'(first));
        end

        // Reset in the middle of a frame: leftover must drain as one orphan.
        clear_counts();
        make_frame(30, 0, w); push_words(0, w);
        c = 0;
        while (rd_total[0] < 5 && c < 200) begin cycle(); c++; end
        chk("midrst_reached_word5", 64'(rd_total[0]), 5);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        clear_counts();
        for (int p = 0; p < PN; p++) begin
            tmp = fifo_q[p];
            fifo_q[p].delete();
            exp_q[p].delete();
            push_words(p, tmp);
        end
        prev_fwd_ok = 0; prev_wr = 0; prev_trunc = 0; prev_orphan = 0;
        in_frame = 0; last_data = 9'd0;
        repeat (2) cycle();
        reset_n = 1'b1;
        run_drain("midrst", 500);
        chk("midrst_orphan", 64'(orphan_seen), 1);
        chk("midrst_writes", 64'(wr_total), 0);

        // Randomized traffic with random back-pressure and FIFO gaps.
        clear_counts();
        for (int f = 0; f < 40; f++) begin
            make_frame($urandom_range(2, 90), ($urandom_range(9) == 0) ? 1 : 0, w);
            push_words($urandom_range(PN - 1), w);
        end
        exp_words = 0;
        for (int p = 0; p < PN; p++) exp_words += exp_q[p].size();
        rand_full_pct = 25;
        rand_gap_pct  = 15;
        run_drain("random", 40000);
        rand_full_pct = 0;
        rand_gap_pct  = 0;
        chk("random_writes", 64'(wr_total), 64'(exp_words));
        chk("random_trunc", 64'(trunc_seen), 64'(exp_trunc));
        chk("random_orphan", 64'(orphan_seen), 64'(exp_orphan));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
